param_sync_fifo: RTL and testbench

- Single-clock, parametrised FIFO for serial/GPIO data paths (UART RX/TX buffering).
- Successor to the fixed 9x16 FIFO, generalised in width, depth and flag thresholds.
- Requests are edge-qualified internally, so level-held strobes from the bus register interface each produce exactly one transfer.
- Adds correct full/empty under wrap, sticky overflow/underflow, programmable almost-flags and an exact fill level.

---
 rtl/fifo_pkg.sv | 15 +
 rtl/edge_detect.sv | 18 +
 rtl/param_sync_fifo.sv | 102 ++++++++++
 tb/tb_param_sync_fifo.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parametrised synchronous FIFO.
package fifo_pkg;

  typedef enum logic [1:0] {
    EVT_NONE,
    EVT_WRITE,
    EVT_READ,
    EVT_BOTH
  } fifo_evt_t;

  function automatic int fifo_aw(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge qualifier: a level-held request yields a single one-cycle pulse.
module edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic out
);

  logic in_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) in_d <= 1'b0;
    else       in_d <= in;
  end

  assign out = in & ~in_d;

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock parametrised FIFO with edge-qualified requests, sticky error flags and fill level.
// Optional peak fill tracking is enabled with FIFO_PEAK_WATERMARK_EN.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W     = 9,
  parameter int DEPTH      = 16,
  parameter int AFULL_LVL  = 12,
  parameter int AEMPTY_LVL = 4,
  localparam int AW        = fifo_aw(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_request,
  input  logic              rd_request,
  input  logic              clear_overflow_request,
  input  logic              clear_underflow_request,
`ifdef FIFO_PEAK_WATERMARK_EN
  input  logic              clear_peak_request,
  output logic [AW:0]       peak_watermark,
`endif
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow,
  output logic [AW:0]       wr_index,
  output logic [AW:0]       rd_index,
  output logic [AW:0]       watermark
);

  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0] AFULL_W  = (AW+1)'(AFULL_LVL);
  localparam logic [AW:0] AEMPTY_W = (AW+1)'(AEMPTY_LVL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_pulse, rd_pulse;
  logic              wr_ok, rd_ok;
  logic              ovf_set, unf_set;
  fifo_evt_t         evt;

  edge_detect u_wr_edge (.clock(clock), .reset(reset), .in(wr_request), .out(wr_pulse));
  edge_detect u_rd_edge (.clock(clock), .reset(reset), .in(rd_request), .out(rd_pulse));

  assign empty        = (wr_index == rd_index);
  assign full         = (wr_index[AW] != rd_index[AW]) && (wr_index[AW-1:0] == rd_index[AW-1:0]);
  assign watermark    = wr_index - rd_index;
  assign almost_full  = (watermark >= AFULL_W);
  assign almost_empty = (watermark <= AEMPTY_W);

  // A write into a full FIFO is still accepted when a read frees the slot on the same edge.
  always_comb begin
    evt = EVT_NONE;
    unique case ({wr_pulse, rd_pulse})
      2'b10:   evt = full  ? EVT_NONE  : EVT_WRITE;
      2'b01:   evt = empty ? EVT_NONE  : EVT_READ;
      2'b11:   evt = empty ? EVT_WRITE : EVT_BOTH;
      default: evt = EVT_NONE;
    endcase
  end

  assign wr_ok   = (evt == EVT_WRITE) || (evt == EVT_BOTH);
  assign rd_ok   = (evt == EVT_READ)  || (evt == EVT_BOTH);
  assign ovf_set = wr_pulse & full & ~rd_pulse;
  assign unf_set = rd_pulse & empty;

  always_ff @(posedge clock) begin
    if (wr_ok) mem[wr_index[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_data   <= '0;
      wr_index  <= '0;
      rd_index  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_index <= wr_index + PTR_ONE;
      if (rd_ok) begin
        rd_data  <= mem[rd_index[AW-1:0]];
        rd_index <= rd_index + PTR_ONE;
      end
      if (ovf_set)                     overflow <= 1'b1;
      else if (clear_overflow_request) overflow <= 1'b0;
      if (unf_set)                      underflow <= 1'b1;
      else if (clear_underflow_request) underflow <= 1'b0;
    end
  end

`ifdef FIFO_PEAK_WATERMARK_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                          peak_watermark <= '0;
    else if (clear_peak_request)        peak_watermark <= watermark;
    else if (watermark > peak_watermark) peak_watermark <= watermark;
  end
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// Scoreboard bench for param_sync_fifo: queue-based reference model, per-cycle monitor on the falling edge.
module tb_param_sync_fifo;

  localparam int DATA_W = 9;
  localparam int DEPTH  = 16;
  localparam int AW     = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              wr_request = 1'b0, rd_request = 1'b0;
  logic              clear_overflow_request = 1'b0, clear_underflow_request = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic [DATA_W-1:0] rd_data;
  logic              empty, full, almost_full, almost_empty, overflow, underflow;
  logic [AW:0]       wr_index, rd_index, watermark;
`ifdef FIFO_PEAK_WATERMARK_EN
  logic              clear_peak_request = 1'b0;
  logic [AW:0]       peak_watermark;
`endif

  param_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_LVL(12), .AEMPTY_LVL(4)) dut (
    .clock(clock), .reset(reset),
    .wr_request(wr_request), .rd_request(rd_request),
    .clear_overflow_request(clear_overflow_request),
    .clear_underflow_request(clear_underflow_request),
`ifdef FIFO_PEAK_WATERMARK_EN
    .clear_peak_request(clear_peak_request), .peak_watermark(peak_watermark),
`endif
    .wr_data(wr_data), .rd_data(rd_data),
    .empty(empty), .full(full), .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow),
    .wr_index(wr_index), .rd_index(rd_index), .watermark(watermark)
  );

  always #5 clock = ~clock;

  // Reference model state
  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] last_rd_exp = '0;
  logic [AW:0]       wr_cnt = '0, rd_cnt = '0;
  logic              ov_m = 1'b0, un_m = 1'b0;
  int                peak_m = 0;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_q.delete();
    last_rd_exp = '0;
    wr_cnt = '0;
    rd_cnt = '0;
    ov_m = 1'b0;
    un_m = 1'b0;
    peak_m = 0;
  endtask

  // Called just after a committing edge with the request values that were presented to it.
  task automatic model_commit(input bit w, input bit r, input logic [DATA_W-1:0] d,
                              input bit co, input bit cu);
    bit full_m, empty_m, wacc, racc;
    full_m  = (q.size() == DEPTH);
    empty_m = (q.size() == 0);
    wacc = w && (!full_m || r);
    racc = r && !empty_m;
    if (racc) begin
      exp_q.push_back(q.pop_front());
      rd_cnt++;
    end
    if (wacc) begin
      q.push_back(d);
      wr_cnt++;
    end
    if (w && full_m && !r) ov_m = 1'b1;
    else if (co)           ov_m = 1'b0;
    if (r && empty_m)      un_m = 1'b1;
    else if (cu)           un_m = 1'b0;
  endtask

  // One transfer: requests presented for one edge, then dropped for one edge. Entered at posedge+1.
  task automatic op(input bit w, input bit r, input logic [DATA_W-1:0] d,
                    input bit co, input bit cu);
    wr_request = w;
    rd_request = r;
    wr_data    = d;
    clear_overflow_request  = co;
    clear_underflow_request = cu;
    @(posedge clock);
    #1;
    model_commit(w, r, d, co, cu);
    wr_request = 1'b0;
    rd_request = 1'b0;
    clear_overflow_request  = 1'b0;
    clear_underflow_request = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic hold_write(input logic [DATA_W-1:0] d, input int cycles);
    wr_request = 1'b1;
    wr_data    = d;
    @(posedge clock);
    #1;
    model_commit(1'b1, 1'b0, d, 1'b0, 1'b0);
    repeat (cycles - 1) @(posedge clock);
    #1;
    wr_request = 1'b0;
    @(posedge clock);
    #1;
  endtask

  // Monitor: compares every flag and index each cycle, and pops the scoreboard on each read.
  logic [AW:0] prev_rd_idx = '0;
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_rd_idx = rd_index;
      end else if (rd_index != prev_rd_idx) begin
        prev_rd_idx = rd_index;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rd_unexpected: rd_index moved to %0d with no read expected", rd_index);
        end else begin
          last_rd_exp = exp_q.pop_front();
        end
      end
      chk("rd_data",      32'(rd_data),      32'(last_rd_exp));
      chk("watermark",    32'(watermark),    32'(q.size()));
      chk("empty",        32'(empty),        32'(q.size() == 0));
      chk("full",         32'(full),         32'(q.size() == DEPTH));
      chk("almost_full",  32'(almost_full),  32'(q.size() >= 12));
      chk("almost_empty", 32'(almost_empty), 32'(q.size() <= 4));
      chk("overflow",     32'(overflow),     32'(ov_m));
      chk("underflow",    32'(underflow),    32'(un_m));
      chk("wr_index",     32'(wr_index),     32'(wr_cnt));
      chk("rd_index",     32'(rd_index),     32'(rd_cnt));
`ifdef FIFO_PEAK_WATERMARK_EN
      chk("peak_watermark", 32'(peak_watermark), 32'(peak_m));
      if (reset) peak_m = 0;
      else if (q.size() > peak_m) peak_m = q.size();
`endif
    end
  end

  initial begin
    logic [DATA_W-1:0] d;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Fill to full.
    for (int i = 0; i < DEPTH; i++) op(1'b1, 1'b0, DATA_W'(9'h100 + i), 1'b0, 1'b0);
    chk("t1_full",      32'(full),      32'd1);
    chk("t1_watermark", 32'(watermark), 32'd16);
    chk("t1_wr_index",  32'(wr_index),  32'b10000);
    chk("t1_overflow",  32'(overflow),  32'd0);

    // Overflowing write, then drain.
    op(1'b1, 1'b0, 9'h1AA, 1'b0, 1'b0);
    chk("t2_overflow", 32'(overflow), 32'd1);
    chk("t2_wr_index", 32'(wr_index), 32'b10000);
    for (int i = 0; i < DEPTH; i++) op(1'b0, 1'b1, '0, 1'b0, 1'b0);
    chk("t2_empty",   32'(empty),   32'd1);
    chk("t2_last_rd", 32'(rd_data), 32'h10F);
    op(1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("t2_ovf_clr", 32'(overflow), 32'd0);

    // Underflow; clear coinciding with a rejected read keeps it set.
    op(1'b0, 1'b1, '0, 1'b0, 1'b0);
    chk("t3_underflow", 32'(underflow), 32'd1);
    chk("t3_rd_hold",   32'(rd_data),   32'h10F);
    op(1'b0, 1'b1, '0, 1'b0, 1'b1);
    chk("t3_set_wins",  32'(underflow), 32'd1);
    op(1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("t3_unf_clr",   32'(underflow), 32'd0);

    // Level-held write produces one transfer.
    hold_write(9'h055, 10);
    chk("t4_watermark", 32'(watermark), 32'd1);

    // Interleaved pairs across the pointer wrap.
    for (int i = 0; i < 40; i++) begin
      op(1'b1, 1'b0, DATA_W'($urandom_range(0, 511)), 1'b0, 1'b0);
      op(1'b0, 1'b1, '0, 1'b0, 1'b0);
    end
    while (q.size() < DEPTH) op(1'b1, 1'b0, DATA_W'($urandom_range(0, 511)), 1'b0, 1'b0);
    op(1'b1, 1'b1, DATA_W'($urandom_range(0, 511)), 1'b0, 1'b0);
    chk("t5_full_both", 32'(watermark), 32'd16);
    chk("t5_no_ovf",    32'(overflow),  32'd0);
    while (q.size() > 0) op(1'b0, 1'b1, '0, 1'b0, 1'b0);
    op(1'b1, 1'b1, DATA_W'($urandom_range(0, 511)), 1'b0, 1'b0);
    chk("t5_empty_both", 32'(watermark), 32'd1);
    chk("t5_empty_unf",  32'(underflow), 32'd1);
    op(1'b0, 1'b0, '0, 1'b1, 1'b1);

    for (int i = 0; i < 120; i++) begin
      op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DATA_W'($urandom_range(0, 511)),
         ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
    end

    // Asynchronous reset mid-burst at level 7.
    while (q.size() > 0) op(1'b0, 1'b1, '0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) op(1'b1, 1'b0, DATA_W'($urandom_range(0, 511)), 1'b0, 1'b0);
    chk("t6_level7", 32'(watermark), 32'd7);
    wr_request = 1'b1;
    wr_data    = 9'h0AB;
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rd_data",   32'(rd_data),      32'd0);
    chk("t6_wr_index",  32'(wr_index),     32'd0);
    chk("t6_rd_index",  32'(rd_index),     32'd0);
    chk("t6_watermark", 32'(watermark),    32'd0);
    chk("t6_empty",     32'(empty),        32'd1);
    chk("t6_full",      32'(full),         32'd0);
    chk("t6_aempty",    32'(almost_empty), 32'd1);
    chk("t6_afull",     32'(almost_full),  32'd0);
    chk("t6_overflow",  32'(overflow),     32'd0);
    chk("t6_underflow", 32'(underflow),    32'd0);
    model_reset();
    wr_request = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    op(1'b1, 1'b0, 9'h1FF, 1'b0, 1'b0);
    op(1'b0, 1'b1, '0, 1'b0, 1'b0);
    d = rd_data;
    chk("t6_roundtrip", 32'(d), 32'h1FF);
    @(posedge clock);
    #1;
    chk("t6_sb_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
